match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Match sequencer for the two-player game. Consumes the decoded button levels
//  (pone_dive/kick, ptwo_dive/kick, game_start) and hit pulses from collision logic.
//  Runs the match FSM (IDLE/COUNTDOWN/FIGHT/ROUND_OVER/MATCH_OVER) and keeps the score.
//  Issues at most one dive/kick command per player per video frame, and only in FIGHT.
// PARAMETERS
//  COUNTDOWN_FRAMES  180  frames spent in COUNTDOWN before FIGHT (>=1)
//  ROUND_OVER_FRAMES 120  frames spent in ROUND_OVER freeze (>=1)
//  WIN_SCORE         5    round wins that end the match (1..2^SCORE_W-1)
//  SCORE_W           3    width of each score counter
// PORTS
//  Clk          in   1        system clock
//  Reset_n      in   1        asynchronous active-low reset
//  frame_tick   in   1        one-cycle pulse per video frame (vsync)
//  pone_dive    in   1        level, P1 dive key held
//  pone_kick    in   1        level, P1 kick key held
//  ptwo_dive    in   1        level, P2 dive key held
//  ptwo_kick    in   1        level, P2 kick key held
//  game_start   in   1        level, start key held
//  hit_pone     in   1        one-cycle pulse: P1 was struck
//  hit_ptwo     in   1        one-cycle pulse: P2 was struck
//  state        out  3        0 IDLE,1 COUNTDOWN,2 FIGHT,3 ROUND_OVER,4 MATCH_OVER
//  p1_dive_cmd  out  1        one-cycle command pulse; same for the three below
//  p1_kick_cmd  out  1
//  p2_dive_cmd  out  1
//  p2_kick_cmd  out  1
//  frames_left  out  8        remaining frames in COUNTDOWN/ROUND_OVER, else 0
//  score_p1     out  SCORE_W  P1 round wins
//  score_p2     out  SCORE_W  P2 round wins
//  round_result out  2        last round: 0 none,1 P1 won,2 P2 won,3 draw
//  match_winner out  2        0 none,1 P1,2 P2; valid in MATCH_OVER
// BEHAVIOUR
//  Reset: state=IDLE; all cmds, frames_left, scores, round_result, match_winner = 0.
//  Reset also loads the previous-level regs of all 5 keys to 1, so a key held
//  through reset produces no edge.
//  Edge detect: press = level & ~prev, registered every Clk.
//  Each of the 4 action keys has a pending bit, set on press only in FIGHT.
//  On frame_tick in FIGHT: cmd = pending (registered, high 1 Clk); pending cleared.
//  A press in the same cycle as frame_tick is kept pending for the next frame.
//  Multiple presses within one frame collapse to one cmd.
//  Press-and-release within one frame still yields one cmd.
//  Pending bits are cleared on any entry to FIGHT and on any exit from it.
//  Outside FIGHT all cmds stay 0.
//  IDLE: game_start press -> COUNTDOWN; frames_left=COUNTDOWN_FRAMES.
//  COUNTDOWN: frames_left-1 per frame_tick; tick with frames_left==1 -> FIGHT, frames_left=0.
//  FIGHT: hit_ptwo only -> P1 scores, round_result=1; hit_pone only -> P2 scores, =2.
//   Both hits in the same cycle -> draw, round_result=3, no score change.
//   Every case goes to ROUND_OVER, frames_left=ROUND_OVER_FRAMES.
//   Hits win over a same-cycle frame_tick: no cmd is issued on that tick.
//  ROUND_OVER: counts down like COUNTDOWN; at expiry, any score==WIN_SCORE ->
//   MATCH_OVER with match_winner set; otherwise COUNTDOWN reloaded.
//  MATCH_OVER: game_start press -> scores, round_result, match_winner cleared;
//   -> COUNTDOWN.
//  hit_* outside FIGHT and game_start outside IDLE/MATCH_OVER are ignored.
//  Scores saturate at 2^SCORE_W-1; no wrap. frames_left never wraps below 0.
//  Reset_n low at any time aborts immediately to reset values.
// TESTING
//  1 Reset with game_start held, release Reset_n -> stays IDLE; release+press -> COUNTDOWN, frames_left=180.
//  2 COUNTDOWN_FRAMES=3: three frame_ticks -> FIGHT on 3rd; presses during countdown give no cmds.
//  3 FIGHT: 3 pone_dive presses between ticks -> exactly one p1_dive_cmd pulse at next tick+1.
//  4 hit_pone & hit_ptwo same cycle -> ROUND_OVER, round_result=3, scores 0/0.
//  5 WIN_SCORE=2: two hit_ptwo rounds -> score_p1=2, MATCH_OVER, match_winner=1; start -> scores 0.
//  6 Reset_n pulsed mid-FIGHT with pending set -> IDLE, no cmd after release.

Source files
------------

// File: rtl/match_ctrl.sv
// Match sequencer: edge-detects keys, runs the round FSM, keeps score
// and issues at most one action command per key per video frame.
module match_ctrl #(
  parameter int COUNTDOWN_FRAMES  = 180,
  parameter int ROUND_OVER_FRAMES = 120,
  parameter int WIN_SCORE         = 5,
  parameter int SCORE_W           = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               pone_dive,
  input  logic               pone_kick,
  input  logic               ptwo_dive,
  input  logic               ptwo_kick,
  input  logic               game_start,
  input  logic               hit_pone,
  input  logic               hit_ptwo,
  output logic [2:0]         state,
  output logic               p1_dive_cmd,
  output logic               p1_kick_cmd,
  output logic               p2_dive_cmd,
  output logic               p2_kick_cmd,
  output logic [7:0]         frames_left,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         round_result,
  output logic [1:0]         match_winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CD    = 3'd1,
    S_FIGHT = 3'd2,
    S_RO    = 3'd3,
    S_MO    = 3'd4
  } state_e;

  localparam logic [7:0] CD_F = 8'(COUNTDOWN_FRAMES);
  localparam logic [7:0] RO_F = 8'(ROUND_OVER_FRAMES);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  state_e             state_q, state_d;
  logic [4:0]         prev_q, prev_d;
  logic [3:0]         pend_q, pend_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [7:0]         frames_q, frames_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0]         rr_q, rr_d, mw_q, mw_d;
  logic [4:0]         keys, press;

  // key order: {start, p2 kick, p2 dive, p1 kick, p1 dive}
  assign keys = {game_start, ptwo_kick, ptwo_dive, pone_kick, pone_dive};
  assign press = keys & ~prev_q;

  always_comb begin
    state_d  = state_q;
    prev_d   = keys;
    pend_d   = '0;
    cmd_d    = '0;
    frames_d = frames_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    rr_d     = rr_q;
    mw_d     = mw_q;
    unique case (state_q)
      S_IDLE: begin
        frames_d = '0;
        if (press[4]) begin
          state_d  = S_CD;
          frames_d = CD_F;
        end
      end
      S_CD: begin
        if (frame_tick) begin
          if (frames_q <= 8'd1) begin
            state_d  = S_FIGHT;
            frames_d = '0;
          end else begin
            frames_d = frames_q - 8'd1;
          end
        end
      end
      S_FIGHT: begin
        frames_d = '0;
        if (hit_pone || hit_ptwo) begin
          state_d  = S_RO;
          frames_d = RO_F;
          if (hit_pone && hit_ptwo) begin
            rr_d = 2'd3;
          end else if (hit_ptwo) begin
            rr_d = 2'd1;
            if (s1_q != SMAX) s1_d = s1_q + 1'b1;
          end else begin
            rr_d = 2'd2;
            if (s2_q != SMAX) s2_d = s2_q + 1'b1;
          end
        end else if (frame_tick) begin
          // a press on the tick itself rolls into the next frame
          cmd_d  = pend_q;
          pend_d = press[3:0];
        end else begin
          pend_d = pend_q | press[3:0];
        end
      end
      S_RO: begin
        if (frame_tick) begin
          if (frames_q <= 8'd1) begin
            if (s1_q == WIN || s2_q == WIN) begin
              state_d  = S_MO;
              frames_d = '0;
              mw_d     = (s1_q == WIN) ? 2'd1 : 2'd2;
            end else begin
              state_d  = S_CD;
              frames_d = CD_F;
            end
          end else begin
            frames_d = frames_q - 8'd1;
          end
        end
      end
      S_MO: begin
        frames_d = '0;
        if (press[4]) begin
          state_d  = S_CD;
          frames_d = CD_F;
          s1_d     = '0;
          s2_d     = '0;
          rr_d     = '0;
          mw_d     = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        frames_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      prev_q   <= '1;
      pend_q   <= '0;
      cmd_q    <= '0;
      frames_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      rr_q     <= '0;
      mw_q     <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      cmd_q    <= cmd_d;
      frames_q <= frames_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rr_q     <= rr_d;
      mw_q     <= mw_d;
    end
  end

  assign state        = state_q;
  assign p1_dive_cmd  = cmd_q[0];
  assign p1_kick_cmd  = cmd_q[1];
  assign p2_dive_cmd  = cmd_q[2];
  assign p2_kick_cmd  = cmd_q[3];
  assign frames_left  = frames_q;
  assign score_p1     = s1_q;
  assign score_p2     = s2_q;
  assign round_result = rr_q;
  assign match_winner = mw_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: command pulses go through a scoreboard queue,
// FSM and score values are checked inline per scenario.
module tb_match_ctrl;

  localparam int CDF = 3;
  localparam int ROF = 2;
  localparam int WS  = 2;
  localparam int SW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_tick;
  logic [3:0]    keys;
  logic          game_start;
  logic          hit_pone, hit_ptwo;
  logic [2:0]    state;
  logic          p1d, p1k, p2d, p2k;
  logic [7:0]    frames_left;
  logic [SW-1:0] score_p1, score_p2;
  logic [1:0]    round_result, match_winner;
  logic [3:0]    cmds;

  int compared = 0;
  int failed   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  always #5 clk = ~clk;

  match_ctrl #(
    .COUNTDOWN_FRAMES (CDF),
    .ROUND_OVER_FRAMES(ROF),
    .WIN_SCORE        (WS),
    .SCORE_W          (SW)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .frame_tick  (frame_tick),
    .pone_dive   (keys[0]),
    .pone_kick   (keys[1]),
    .ptwo_dive   (keys[2]),
    .ptwo_kick   (keys[3]),
    .game_start  (game_start),
    .hit_pone    (hit_pone),
    .hit_ptwo    (hit_ptwo),
    .state       (state),
    .p1_dive_cmd (p1d),
    .p1_kick_cmd (p1k),
    .p2_dive_cmd (p2d),
    .p2_kick_cmd (p2k),
    .frames_left (frames_left),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .round_result(round_result),
    .match_winner(match_winner)
  );

  assign cmds = {p2k, p2d, p1k, p1d};

  // any command pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (cmds !== 4'b0000) begin
      compared++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_cmd got %b want none", cmds);
      end else begin
        exp_v = exp_q.pop_front();
        if (cmds !== exp_v) begin
          failed++;
          $display("FAIL cmd_value got %b want %b", cmds, exp_v);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic press(input logic [3:0] k);
    keys = keys | k;
    step();
    keys = keys & ~k;
    step();
  endtask

  task automatic press_start();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    game_start = 1'b1;
    step(2);
    compared++;
    if ({state, frames_left, score_p1, score_p2, round_result, match_winner, cmds}
        !== '0) begin
      failed++;
      $display("FAIL reset_vals got st=%0d fl=%0d s=%0d/%0d rr=%0d mw=%0d c=%b want all 0",
               state, frames_left, score_p1, score_p2, round_result,
               match_winner, cmds);
    end
    rst_n = 1'b1;
    step(3);
    compared++;
    if (state !== 3'd0) begin
      failed++;
      $display("FAIL held_start got %0d want 0", state);
    end
    game_start = 1'b0;
    step();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    compared++;
    if (state !== 3'd1 || frames_left !== 8'(CDF)) begin
      failed++;
      $display("FAIL start_cd got st=%0d fl=%0d want 1/%0d", state, frames_left, CDF);
    end
    step();
  endtask

  task automatic test_countdown();
    press(4'b0011);
    press_start();
    tick();
    compared++;
    if (state !== 3'd1 || frames_left !== 8'd2) begin
      failed++;
      $display("FAIL cd_tick1 got st=%0d fl=%0d want 1/2", state, frames_left);
    end
    press(4'b0001);
    tick();
    compared++;
    if (state !== 3'd1 || frames_left !== 8'd1) begin
      failed++;
      $display("FAIL cd_tick2 got st=%0d fl=%0d want 1/1", state, frames_left);
    end
    tick();
    compared++;
    if (state !== 3'd2 || frames_left !== 8'd0) begin
      failed++;
      $display("FAIL cd_fight got st=%0d fl=%0d want 2/0", state, frames_left);
    end
    tick();
  endtask

  task automatic test_collapse();
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    exp_q.push_back(4'b0001);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL collapse_timing got pending=%0d want 0", exp_q.size());
    end
    step();
    press(4'b0110);
    exp_q.push_back(4'b0110);
    tick();
    keys = 4'b1000;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    keys = 4'b0000;
    step(2);
    exp_q.push_back(4'b1000);
    tick();
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL tick_press got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_draw();
    press(4'b0001);
    hit_pone = 1'b1;
    hit_ptwo = 1'b1;
    frame_tick = 1'b1;
    step();
    hit_pone = 1'b0;
    hit_ptwo = 1'b0;
    frame_tick = 1'b0;
    compared++;
    if (state !== 3'd3 || round_result !== 2'd3 || frames_left !== 8'(ROF) ||
        score_p1 !== '0 || score_p2 !== '0) begin
      failed++;
      $display("FAIL draw got st=%0d rr=%0d fl=%0d s=%0d/%0d want 3/3/%0d/0/0",
               state, round_result, frames_left, score_p1, score_p2, ROF);
    end
    hit_pone = 1'b1;
    step();
    hit_pone = 1'b0;
    tick(2);
    compared++;
    if (state !== 3'd1 || frames_left !== 8'(CDF) || score_p2 !== '0) begin
      failed++;
      $display("FAIL draw_next got st=%0d fl=%0d s2=%0d want 1/%0d/0",
               state, frames_left, score_p2, CDF);
    end
    tick(CDF);
  endtask

  task automatic test_win();
    hit_ptwo = 1'b1;
    step();
    hit_ptwo = 1'b0;
    compared++;
    if (score_p1 !== 3'd1 || round_result !== 2'd1) begin
      failed++;
      $display("FAIL round1 got s1=%0d rr=%0d want 1/1", score_p1, round_result);
    end
    tick(ROF);
    tick(CDF);
    hit_ptwo = 1'b1;
    step();
    hit_ptwo = 1'b0;
    tick(ROF);
    compared++;
    if (state !== 3'd4 || score_p1 !== 3'd2 || match_winner !== 2'd1) begin
      failed++;
      $display("FAIL match_over got st=%0d s1=%0d mw=%0d want 4/2/1",
               state, score_p1, match_winner);
    end
    hit_pone = 1'b1;
    step();
    hit_pone = 1'b0;
    compared++;
    if (score_p2 !== 3'd0 || state !== 3'd4) begin
      failed++;
      $display("FAIL hit_ignored got s2=%0d st=%0d want 0/4", score_p2, state);
    end
    press_start();
    compared++;
    if (state !== 3'd1 || score_p1 !== '0 || round_result !== 2'd0 ||
        match_winner !== 2'd0 || frames_left !== 8'(CDF - 0)) begin
      failed++;
      $display("FAIL restart got st=%0d s1=%0d rr=%0d mw=%0d fl=%0d want 1/0/0/0/%0d",
               state, score_p1, round_result, match_winner, frames_left, CDF);
    end
  endtask

  task automatic test_reset_mid();
    tick(CDF);
    press(4'b0010);
    rst_n = 1'b0;
    #1;
    compared++;
    if (state !== 3'd0 || frames_left !== 8'd0) begin
      failed++;
      $display("FAIL async_reset got st=%0d fl=%0d want 0/0", state, frames_left);
    end
    step();
    rst_n = 1'b1;
    tick(2);
    compared++;
    if (state !== 3'd0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL post_reset got st=%0d pending=%0d want 0/0", state, exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    keys = 4'b0000;
    game_start = 1'b0;
    hit_pone = 1'b0;
    hit_ptwo = 1'b0;
    test_reset();
    test_countdown();
    test_collapse();
    test_draw();
    test_win();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
